// File: rtl/scan_pkg.sv
// Shared types and widths for the row scan sequencer and its dwell timer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SEL_W       = 3;
    localparam int FRAME_CNT_W = 8;

    // Dwell counter width: enough to hold DWELL_CYCLES-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts the cycles a row is held and flags the last cycle of each dwell period.
module dwell_timer
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    localparam int CNT_W = cnt_width(DWELL_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick only while counting, so an idle counter parked at zero never pulses.
    assign tick = en && (cnt_q == LAST_CNT);
    assign cnt  = cnt_q;

    // Next count: clear wins, otherwise wrap to zero on the last dwell cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Dwell counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/row_scan_sequencer.sv
// Generates the 0..LAST_ROW row select sequence for the 3-to-8 row decoder,
// holding each row for DWELL_CYCLES, in one-shot or continuous mode.
module row_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int LAST_ROW     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   one_shot,
    output logic [SEL_W-1:0]       sel,
    output logic                   sel_valid,
    output logic                   row_tick,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int               CNT_W      = cnt_width(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(LAST_ROW);

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   mode_q, mode_d;

    logic [CNT_W-1:0]       dwell_cnt;
    logic                   dwell_tick;
    logic                   scanning;
    logic                   row_end;

    assign scanning = (state_q == SCAN);
    assign row_end  = scanning && (dwell_cnt == LAST_DWELL);

    // The timer is held at zero outside SCAN and when a stop aborts the scan.
    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!scanning || stop),
        .en   (scanning),
        .cnt  (dwell_cnt),
        .tick (dwell_tick)
    );

    assign sel         = sel_q;
    assign sel_valid   = vld_q;
    assign row_tick    = dwell_tick;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = frame_q;

    // Next-state logic: stop overrides everything in SCAN, including a frame-ending tick.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        frame_d = frame_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                    mode_d  = one_shot;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (row_end) begin
                    if (sel_q < LAST_SEL) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        frame_d = frame_q + FRAME_CNT_W'(1);
                        sel_d   = '0;
                        if (mode_q) begin
                            state_d = DONE;
                            vld_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, select, handshake and frame counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frame_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Scoreboard bench for row_scan_sequencer: expected rows are queued when a scan
// is launched, and a negedge monitor pops one entry per sel_valid cycle.
module tb_row_scan_sequencer;

    localparam int D  = 4;
    localparam int R  = 8;
    localparam int FL = D * R;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       one_shot;
    logic [2:0] sel;
    logic       sel_valid;
    logic       row_tick;
    logic       busy;
    logic       done;
    logic [7:0] frame_count;

    row_scan_sequencer #(
        .DWELL_CYCLES(D),
        .LAST_ROW    (R - 1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .one_shot    (one_shot),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .row_tick    (row_tick),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       tick;
        logic [7:0] fc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] done_q[$];
    logic [7:0] model_fc;
    int         n_vec = 0;
    int         n_err = 0;
    exp_t       mon_e;
    logic [7:0] mon_f;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: valid cycle i shows row (i/D) mod R, ticks on the last dwell cycle,
    // and has seen i/FL completed frames since the scan began.
    task automatic push_scan(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sel  = 3'((i / D) % R);
            e.tick = ((i % D) == D - 1);
            e.fc   = model_fc + 8'(i / FL);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one scoreboard entry per valid cycle; idle cycles must be quiet.
    always @(negedge clk) begin
        if (!rst) begin
            if (sel_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(sel_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sel", 32'(sel), 32'(mon_e.sel));
                    check("row_tick", 32'(row_tick), 32'(mon_e.tick));
                    check("frame_count", 32'(frame_count), 32'(mon_e.fc));
                    check("busy_in_scan", 32'(busy), 32'd1);
                end
            end else begin
                check("idle_row_tick", 32'(row_tick), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_f = done_q.pop_front();
                    check("done_frame_count", 32'(frame_count), 32'(mon_f));
                    check("done_sel", 32'(sel), 32'd0);
                end
            end
        end
    end

    // Launch a scan of s valid cycles; end it with stop in cycle s-1, or let a
    // one-shot frame complete (s == FL) and exercise start during DONE.
    task automatic run_scan(input bit os, input int s, input bit do_stop);
        push_scan(s);
        if (!do_stop) done_q.push_back(model_fc + 8'd1);
        start    = 1'b1;
        one_shot = os;
        stop     = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i < s; i++) begin
            start    = 1'($urandom_range(0, 1));
            one_shot = 1'($urandom_range(0, 1));
            tick();
        end
        if (do_stop) begin
            stop = 1'b1;
            tick();
            stop  = 1'b0;
            start = 1'b0;
            model_fc = model_fc + 8'((s - 1) / FL);
            check("stop_sel_valid", 32'(sel_valid), 32'd0);
            check("stop_busy", 32'(busy), 32'd0);
            check("stop_done", 32'(done), 32'd0);
            check("stop_sel", 32'(sel), 32'd0);
            check("stop_frame_count", 32'(frame_count), 32'(model_fc));
        end else begin
            start = 1'b0;
            tick();
            model_fc = model_fc + 8'd1;
            check("done_pulse", 32'(done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            start = 1'b1;
            tick();
            check("after_done_busy", 32'(busy), 32'd0);
            check("after_done_valid", 32'(sel_valid), 32'd0);
            check("after_done_pulse", 32'(done), 32'd0);
            start = 1'b0;
            tick();
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        one_shot = 1'b0;
        model_fc = 8'd0;
        #3;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tick", 32'(row_tick), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // start and stop together in IDLE: no transition
        start = 1'b1;
        stop  = 1'b1;
        tick();
        tick();
        check("start_stop_idle_busy", 32'(busy), 32'd0);
        check("start_stop_idle_valid", 32'(sel_valid), 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        tick();

        // full one-shot frame, then stop on the frame-ending tick in both modes
        run_scan(1'b1, FL, 1'b0);
        run_scan(1'b0, FL, 1'b1);
        run_scan(1'b1, FL, 1'b1);
        // continuous across two frame boundaries
        run_scan(1'b0, 80, 1'b1);

        // randomized scans
        repeat (12) begin
            bit os;
            int s;
            bit st;
            os = 1'($urandom_range(0, 1));
            if (os) begin
                s  = int'($urandom_range(1, FL));
                st = (s < FL) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                s  = int'($urandom_range(1, 120));
                st = 1'b1;
            end
            run_scan(os, s, st);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        // asynchronous reset in row 3, dwell count 2
        push_scan(14);
        start    = 1'b1;
        one_shot = 1'b0;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #1 rst = 1'b1;
        #1;
        model_fc = 8'd0;
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_valid", 32'(sel_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tick", 32'(row_tick), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_frame_count", 32'(frame_count), 32'd0);
        check("arst_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) tick();
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_idle_valid", 32'(sel_valid), 32'd0);

        // long continuous run: frame_count wraps past 255
        run_scan(1'b0, 256 * FL + 40, 1'b1);

        tick();
        check("final_exp_queue", 32'(exp_q.size()), 32'd0);
        check("final_done_queue", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/row_scan_sequencer.md
Name: row_scan_sequencer

Overview:
- Upstream stage for the team's 3-to-8 decoder: generates the 3-bit select sequence 0..7 that the decoder turns into one-hot row enables.
- Each row is held for a programmable dwell time; scanning runs either as a single frame (one-shot) or continuously.
- A start/stop/done handshake connects it to the control logic.
- sel[2] maps to decoder A2, sel[1] to A1, sel[0] to A0.

Parameters:
- DWELL_CYCLES, 4, clock cycles each row is held (legal range 1..256).
- LAST_ROW, 7, final select value before wrap (legal range 0..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin scan; sampled in IDLE only.
- stop  input  1  abort scan; sampled in SCAN only.
- one_shot  input  1  mode select, latched when start is accepted: 1 = single frame, 0 = continuous.
- sel  output  3  row select to decoder {A2,A1,A0}.
- sel_valid  output  1  sel is meaningful; decoder enable.
- row_tick  output  1  one-cycle pulse in the last dwell cycle of each row.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse after a one-shot frame completes.
- frame_count  output  8  completed frames, wraps modulo 256.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset (async, immediate, any state):
  - state = IDLE; sel = 0; sel_valid = 0; busy = 0; row_tick = 0; done = 0; frame_count = 0.
  - dwell_cnt = 0; mode latch = 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start = 1 and stop = 0 at edge k -> SCAN after edge k.
  - On that edge: sel = 0, sel_valid = 1, busy = 1, dwell_cnt = 0, mode latch = one_shot.
  - start = 1 and stop = 1 together: stop wins, remain in IDLE.
- SCAN:
  - dwell_cnt increments each cycle.
  - row_tick = 1 combinationally decoded from the registered state when dwell_cnt == DWELL_CYCLES-1.
  - On a tick edge, dwell_cnt -> 0, then:
    - sel < LAST_ROW: sel++.
    - sel == LAST_ROW: frame_count++ (255 -> 0). If mode latch = 0, sel -> 0 and stay in SCAN. If mode latch = 1, go to DONE.
  - DWELL_CYCLES = 1: row_tick high every SCAN cycle; sel advances every cycle.
- stop = 1 in SCAN (highest priority, including on a tick cycle):
  - Next edge: IDLE, sel = 0, sel_valid = 0, busy = 0, dwell_cnt = 0.
  - frame_count is not incremented, even if a frame would have completed on that cycle. done is not asserted.
- DONE (exactly one cycle):
  - done = 1, sel_valid = 0, busy = 0, sel = 0.
  - Next edge -> IDLE unconditionally; start is ignored in DONE.
- start while in SCAN or DONE is ignored. one_shot changes after acceptance have no effect.
- Timing: one frame = (LAST_ROW+1) * DWELL_CYCLES cycles of sel_valid. With defaults, 32 cycles.
- dwell_cnt width = max(1, clog2(DWELL_CYCLES)); no overflow past DWELL_CYCLES-1.

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, SCAN, DONE} (2 bits).
  - SEL_W = 3.
  - FRAME_CNT_W = 8.
- One natural sub-module: dwell_timer.
  - Parameter DWELL_CYCLES.
  - Inputs clr, en. Outputs cnt, tick.
  - Instantiated once.
- Top-level FSM, sel register and frame counter stay in row_scan_sequencer.

Test Plan:
- Reset mid-scan: assert rst at row 3, dwell_cnt 2 -> all outputs zero immediately (asynchronously); after release, stays IDLE until start.
- One-shot frame (defaults): start=1, one_shot=1 for one cycle ->
  - sel steps 0..7, 4 cycles each; sel_valid high 32 cycles; 8 row_tick pulses.
  - done pulses on cycle 33; frame_count = 1; busy low afterwards.
- Continuous wrap: one_shot=0, run 80 cycles ->
  - sel goes 7 -> 0 with no gap cycle; sel_valid never drops.
  - frame_count = 2 at cycle 64; row_tick count = 20.
- Stop on a tick cycle: stop=1 while sel=7 and row_tick=1 ->
  - next cycle IDLE, sel_valid=0, frame_count unchanged, done stays 0.
- Counter wrap and edge cases:
  - Continuous with DWELL_CYCLES=1 for 2048 cycles -> frame_count wraps 255 -> 0.
  - start and stop asserted together in IDLE -> no transition.
  - start asserted during DONE -> ignored.
